// File: rtl/video_timing_gen_if.sv
// Pixel/timing bundle between video_timing_gen (master) and the game core (slave).
// The FLIP request exists only when VTG_FLIP_EN is defined.
interface video_timing_gen_if #(
  parameter int POS_W = 9,
  parameter int CW    = 12
);
  logic             PCE;
  logic [CW-1:0]    iRGB;
  logic [POS_W-1:0] HPOS;
  logic [POS_W-1:0] VPOS;
  logic [CW-1:0]    oRGB;
  logic             HBLK;
  logic             VBLK;
  logic             HSYN;
  logic             VSYN;
  logic             DE;
  logic             LINE_STB;
  logic             FRAME_STB;
`ifdef VTG_FLIP_EN
  logic             FLIP;

  modport master (
    input  PCE, iRGB, FLIP,
    output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, LINE_STB, FRAME_STB
  );
  modport slave (
    output PCE, iRGB, FLIP,
    input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, LINE_STB, FRAME_STB
  );
`else
  modport master (
    input  PCE, iRGB,
    output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, LINE_STB, FRAME_STB
  );
  modport slave (
    output PCE, iRGB,
    input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, LINE_STB, FRAME_STB
  );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with registered blank/sync/DE, masked RGB and line/frame strobes.
// Optional frame-synchronous position flip enabled by defining VTG_FLIP_EN.
module video_timing_gen #(
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 21,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 11,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 22,
  parameter int POS_W    = 9,
  parameter int CW       = 12,
  parameter int SYNC_NEG = 1
) (
  input  logic                MCLK,
  input  logic                RESET_N,
  video_timing_gen_if.master  vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2**POS_W || V_TOTAL > 2**POS_W) begin : g_size_err
      $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in POS_W bits");
    end
  endgenerate

  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
  // Decode thresholds carry one extra bit so a sync window ending exactly at 2**POS_W stays representable.
  localparam logic [POS_W:0] H_ACT = (POS_W+1)'(H_ACTIVE);
  localparam logic [POS_W:0] H_SS  = (POS_W+1)'(H_ACTIVE + H_FP);
  localparam logic [POS_W:0] H_SE  = (POS_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W:0] V_ACT = (POS_W+1)'(V_ACTIVE);
  localparam logic [POS_W:0] V_SS  = (POS_W+1)'(V_ACTIVE + V_FP);
  localparam logic [POS_W:0] V_SE  = (POS_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic SYNC_IDLE = (SYNC_NEG != 0);

  logic [POS_W-1:0] r_hcnt, r_vcnt;
  logic [POS_W-1:0] w_hcnt_next, w_vcnt_next;
  logic [POS_W:0]   w_hx, w_vx;
  logic             w_h_wrap, w_v_wrap;
  logic             w_hblk_next, w_vblk_next, w_hsync_act, w_vsync_act;
  logic             r_hblk, r_vblk, r_hsyn, r_vsyn, r_de;
  logic             r_line_stb, r_frame_stb;
  logic [CW-1:0]    r_orgb;

  assign w_h_wrap    = (r_hcnt == H_LAST);
  assign w_v_wrap    = (r_vcnt == V_LAST);
  assign w_hcnt_next = w_h_wrap ? '0 : r_hcnt + POS_W'(1);
  assign w_vcnt_next = !w_h_wrap ? r_vcnt : (w_v_wrap ? '0 : r_vcnt + POS_W'(1));

  assign w_hx        = {1'b0, w_hcnt_next};
  assign w_vx        = {1'b0, w_vcnt_next};
  assign w_hblk_next = (w_hx >= H_ACT);
  assign w_vblk_next = (w_vx >= V_ACT);
  assign w_hsync_act = (w_hx >= H_SS) && (w_hx < H_SE);
  assign w_vsync_act = (w_vx >= V_SS) && (w_vx < V_SE);

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hcnt      <= H_LAST;
      r_vcnt      <= V_LAST;
      r_hblk      <= 1'b1;
      r_vblk      <= 1'b1;
      r_de        <= 1'b0;
      r_hsyn      <= SYNC_IDLE;
      r_vsyn      <= SYNC_IDLE;
      r_orgb      <= '0;
      r_line_stb  <= 1'b0;
      r_frame_stb <= 1'b0;
    end else if (vif.PCE) begin
      // Mask uses the blanks of the pixel currently presented, giving one pixel of latency.
      r_orgb      <= (r_hblk | r_vblk) ? '0 : vif.iRGB;
      r_hcnt      <= w_hcnt_next;
      r_vcnt      <= w_vcnt_next;
      r_hblk      <= w_hblk_next;
      r_vblk      <= w_vblk_next;
      r_de        <= ~(w_hblk_next | w_vblk_next);
      r_hsyn      <= w_hsync_act ^ SYNC_IDLE;
      r_vsyn      <= w_vsync_act ^ SYNC_IDLE;
      r_line_stb  <= w_h_wrap;
      r_frame_stb <= w_h_wrap & w_v_wrap;
    end else begin
      r_line_stb  <= 1'b0;
      r_frame_stb <= 1'b0;
    end
  end

`ifdef VTG_FLIP_EN
  logic r_flip;

  // Sampled only as the counters land on (0,0) so a frame is never half-flipped.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_flip <= 1'b0;
    end else if (vif.PCE && w_h_wrap && w_v_wrap) begin
      r_flip <= vif.FLIP;
    end
  end

  assign vif.HPOS = (r_flip && r_de) ? POS_W'(H_ACTIVE - 1) - r_hcnt : r_hcnt;
  assign vif.VPOS = (r_flip && r_de) ? POS_W'(V_ACTIVE - 1) - r_vcnt : r_vcnt;
`else
  assign vif.HPOS = r_hcnt;
  assign vif.VPOS = r_vcnt;
`endif

  assign vif.oRGB      = r_orgb;
  assign vif.HBLK      = r_hblk;
  assign vif.VBLK      = r_vblk;
  assign vif.HSYN      = r_hsyn;
  assign vif.VSYN      = r_vsyn;
  assign vif.DE        = r_de;
  assign vif.LINE_STB  = r_line_stb;
  assign vif.FRAME_STB = r_frame_stb;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x7 raster; two instances cover both sync polarities.
// Define VTG_FLIP_EN to also exercise the frame-synchronous flip.
module tb_video_timing_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PW = 4;
  localparam int CW = 8;

  typedef struct {
    logic [31:0] hpos, vpos, hblk, vblk, hsyn, vsyn, hsyn_p, vsyn_p, de, line, frame, orgb;
  } exp_t;

  logic          MCLK = 1'b0;
  logic          RESET_N = 1'b1;
  logic          pce;
  logic [CW-1:0] rgb;
  logic          flip;

  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  exp_t sb[$];

  int m_h, m_v, m_orgb, m_flip, m_line, m_frame;
  int period_exp, since, seen;

  always #5 MCLK = ~MCLK;

  video_timing_gen_if #(.POS_W(PW), .CW(CW)) vif_n();
  video_timing_gen_if #(.POS_W(PW), .CW(CW)) vif_p();

  assign vif_n.PCE  = pce;
  assign vif_n.iRGB = rgb;
  assign vif_p.PCE  = pce;
  assign vif_p.iRGB = rgb;
`ifdef VTG_FLIP_EN
  assign vif_n.FLIP = flip;
  assign vif_p.FLIP = flip;
`endif

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .POS_W(PW), .CW(CW), .SYNC_NEG(1)
  ) u_dut_n (.MCLK(MCLK), .RESET_N(RESET_N), .vif(vif_n));

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .POS_W(PW), .CW(CW), .SYNC_NEG(0)
  ) u_dut_p (.MCLK(MCLK), .RESET_N(RESET_N), .vif(vif_p));

  task automatic model_reset();
    m_h = HT - 1; m_v = VT - 1; m_orgb = 0; m_line = 0; m_frame = 0; m_flip = 0;
  endtask

  task automatic model_clock(input logic p, input logic [CW-1:0] c, input logic f);
    bit blank;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    m_line = 0; m_frame = 0;
    if (!p) return;
    blank  = (m_h >= HA) || (m_v >= VA);
    m_orgb = blank ? 0 : int'(c);
    if (m_h == HT - 1) begin
      m_h = 0; m_line = 1;
      if (m_v == VT - 1) begin
        m_v = 0; m_frame = 1; m_flip = int'(f);
      end else begin
        m_v = m_v + 1;
      end
    end else begin
      m_h = m_h + 1;
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    bit hact, vact, hs, vs;
    hact = (m_h < HA);
    vact = (m_v < VA);
    hs   = (m_h >= HA + HF) && (m_h < HA + HF + HS);
    vs   = (m_v >= VA + VF) && (m_v < VA + VF + VS);
    e.hpos   = (m_flip != 0 && hact && vact) ? HA - 1 - m_h : m_h;
    e.vpos   = (m_flip != 0 && hact && vact) ? VA - 1 - m_v : m_v;
    e.hblk   = hact ? 0 : 1;
    e.vblk   = vact ? 0 : 1;
    e.hsyn   = hs ? 0 : 1;
    e.vsyn   = vs ? 0 : 1;
    e.hsyn_p = hs ? 1 : 0;
    e.vsyn_p = vs ? 1 : 0;
    e.de     = (hact && vact) ? 1 : 0;
    e.line   = m_line;
    e.frame  = m_frame;
    e.orgb   = m_orgb;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, step_no);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    e = sb.pop_front();
    chk("hpos",   32'(vif_n.HPOS),      e.hpos);
    chk("vpos",   32'(vif_n.VPOS),      e.vpos);
    chk("hblk",   32'(vif_n.HBLK),      e.hblk);
    chk("vblk",   32'(vif_n.VBLK),      e.vblk);
    chk("hsyn",   32'(vif_n.HSYN),      e.hsyn);
    chk("vsyn",   32'(vif_n.VSYN),      e.vsyn);
    chk("hsyn_p", 32'(vif_p.HSYN),      e.hsyn_p);
    chk("vsyn_p", 32'(vif_p.VSYN),      e.vsyn_p);
    chk("de",     32'(vif_n.DE),        e.de);
    chk("line",   32'(vif_n.LINE_STB),  e.line);
    chk("frame",  32'(vif_n.FRAME_STB), e.frame);
    chk("orgb",   32'(vif_n.oRGB),      e.orgb);
  endtask

  task automatic check_now();
    sb.push_back(model_outputs());
    compare_pop();
  endtask

  task automatic step(input logic p, input logic [CW-1:0] c);
    pce = p;
    rgb = c;
    model_clock(p, c, flip);
    sb.push_back(model_outputs());
    @(posedge MCLK);
    #1;
    step_no++;
    compare_pop();
    $display("step %0d rst_n=%0b pce=%0b irgb=%02h h=%0d v=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b orgb=%02h",
             step_no, RESET_N, p, c, vif_n.HPOS, vif_n.VPOS, vif_n.DE, vif_n.HSYN, vif_n.VSYN,
             vif_n.LINE_STB, vif_n.FRAME_STB, vif_n.oRGB);
    since++;
    if (vif_n.FRAME_STB === 1'b1) begin
      if (period_exp != 0 && seen != 0) chk("frame_period", 32'(since), 32'(period_exp));
      since = 0;
      seen  = 1;
    end
  endtask

  initial begin
    pce = 1'b0; rgb = '0; flip = 1'b0;
    period_exp = 0; since = 0; seen = 0;
    model_reset();

    // Reset state, asserted asynchronously before any clock edge
    #1 RESET_N = 1'b0;
    #2 check_now();
    step(1'b1, 8'h5a);
    step(1'b0, 8'h00);
    RESET_N = 1'b1;

    // T1 + T3: PCE every cycle, iRGB carries the current position
    period_exp = HT * VT; seen = 0; since = 0;
    step(1'b1, {m_v[3:0], m_h[3:0]});
    chk("first_frame_stb", 32'(vif_n.FRAME_STB), 32'd1);
    chk("first_hpos", 32'(vif_n.HPOS), 32'd0);
    for (int i = 0; i < 2 * HT * VT + 5; i++) step(1'b1, {m_v[3:0], m_h[3:0]});

    // T2: PCE one cycle in three, random pixel data
    period_exp = 3 * HT * VT; seen = 0; since = 0;
    for (int i = 0; i < 2 * HT * VT + 3; i++) begin
      step(1'b1, CW'($urandom));
      step(1'b0, CW'($urandom));
      step(1'b0, CW'($urandom));
    end

    // T4: asynchronous reset at hcnt=5, vcnt=2
    period_exp = 0;
    for (int i = 0; i < 200 && !(m_h == 5 && m_v == 2); i++) step(1'b1, CW'($urandom));
    chk("t4_pre_h", 32'(vif_n.HPOS), 32'd5);
    chk("t4_pre_v", 32'(vif_n.VPOS), 32'd2);
    RESET_N = 1'b0;
    #1;
    model_reset();
    check_now();
    chk("t4_async_hpos", 32'(vif_n.HPOS), 32'(HT - 1));
    step(1'b1, 8'hff);
    step(1'b1, 8'hff);
    RESET_N = 1'b1;
    step(1'b1, 8'h11);
    chk("t4_frame_stb", 32'(vif_n.FRAME_STB), 32'd1);
    chk("t4_vpos", 32'(vif_n.VPOS), 32'd0);
    for (int i = 0; i < 30; i++) step(1'b1, {m_v[3:0], m_h[3:0]});

`ifdef VTG_FLIP_EN
    // T6: flip requested mid-frame takes effect only at the next frame start
    for (int i = 0; i < 200 && !(m_v == 1 && m_h == 3); i++) step(1'b1, CW'($urandom));
    flip = 1'b1;
    step(1'b1, 8'h22);
    chk("t6_hold_hpos", 32'(vif_n.HPOS), 32'd4);
    for (int i = 0; i < 200 && m_frame == 0; i++) step(1'b1, {m_v[3:0], m_h[3:0]});
    chk("t6_flip_hpos", 32'(vif_n.HPOS), 32'(HA - 1));
    chk("t6_flip_vpos", 32'(vif_n.VPOS), 32'(VA - 1));
    flip = 1'b0;
    for (int i = 0; i < HT * VT + 10; i++) step(1'b1, {m_v[3:0], m_h[3:0]});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
